// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter requester agent.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_XFER     = 2'd2,
        ST_YIELD    = 2'd3
    } state_t;

    // Elaboration-time ceil(log2(v)); fixed loop bound keeps it synthesizable.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Small synchronous FIFO; the caller guards push/pop against full/empty.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = clog2(DEPTH),
    parameter int CW     = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/arb_requester.sv
// Arbiter client: buffers words, requests the bus and drains up to MAX_HOLD words per grant.
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int BW = clog2(MAX_HOLD) + 1;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt, beat_nxt;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] head;
    logic              push, pop, full, empty;

    assign in_ready = rst && !full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != ST_IDLE) || !empty;

    arb_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                beat_nxt = '0;
                if (!empty) state_nxt = ST_WAIT_GNT;
            end
            ST_WAIT_GNT: begin
                if (gnt) state_nxt = ST_XFER;
            end
            ST_XFER: begin
                if (!gnt) begin
                    state_nxt = ST_WAIT_GNT;
                end else if (empty) begin
                    state_nxt = ST_YIELD;
                end else begin
                    pop      = 1'b1;
                    beat_nxt = beat_cnt + BW'(1);
                    // Leave when this pop drains the FIFO or the tenure cap is hit.
                    if ((count == CW'(1) && !push) || beat_nxt == BW'(MAX_HOLD))
                        state_nxt = ST_YIELD;
                end
            end
            ST_YIELD: begin
                beat_nxt  = '0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            req       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            req       <= (state_nxt == ST_WAIT_GNT) || (state_nxt == ST_XFER);
            out_valid <= pop;
            if (pop) out_data <= head;
        end
    end

endmodule
